core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle fetch/execute sequencer for the 9-bit-instruction core. Owns the PC, steps
//  FETCH->EXEC(->MEM) per instruction, resolves abs/rel branches from decoder strobes + ALU
//  flags, runs the data-memory req/ack handshake, gates register-file writes, raises done/err.
//  Sits between instruction ROM, control decoder, ALU flags and data memory.
// PARAMETERS
//  PC_W        10   program counter width; PC arithmetic is modulo 2**PC_W
//  OFF_W        6   relative-branch offset width (instr[5:0], two's complement)
//  MEM_TIMEOUT 15   max cycles in MEM waiting for mem_ack before err
//  CNT_W       16   width of the saturating cycle counter
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      begin execution at PC 0 (sampled only in IDLE)
//  instr_off    in   OFF_W  relative offset field of current instruction
//  abs_branch   in   1      decoder AbsBranch strobe
//  rel_branch   in   1      decoder RelBranch strobe
//  branch_flag  in   1      0: test zero flag, 1: test negative flag
//  branch_inv   in   1      invert tested flag
//  mem_write    in   1      decoder MemWrite (store)
//  mem_to_reg   in   1      decoder MemToReg (load)
//  halt_i       in   1      decoder: current instruction is HALT
//  zero_flag    in   1      ALU result == 0
//  neg_flag     in   1      ALU result[7]
//  abs_target   in   PC_W   branch target from register operand
//  mem_ack      in   1      data memory completion
//  pc           out  PC_W   current PC; drives instruction ROM address
//  ir_load      out  1      latch ROM output into instruction register
//  reg_we_en    out  1      AND-gate for decoder RegWrite
//  mem_req      out  1      data-memory request (held until ack)
//  mem_we       out  1      store qualifier, valid with mem_req
//  done         out  1      sticky: halted normally
//  err          out  1      sticky: memory timeout
//  cycle_count  out  CNT_W  cycles since start, saturating at all-ones
// BEHAVIOUR
//  Reset: state=IDLE; pc=0, ir_load=0, reg_we_en=0, mem_req=0, mem_we=0, done=0, err=0, cycle_count=0.
//  FSM: IDLE -start-> FETCH (pc=0, count=0, done/err cleared). FETCH: ir_load=1, 1 cycle -> EXEC.
//   EXEC (instruction valid, decode combinational):
//    halt_i        -> HALT, pc held, no writes (halt wins over any strobe)
//    mem_write|mem_to_reg -> MEM (pc held)
//    else reg_we_en=1 for this cycle; pc updated; -> FETCH
//   MEM: mem_req=1, mem_we=mem_write; on mem_ack: reg_we_en=mem_to_reg same cycle, pc=pc+1, -> FETCH.
//    Wait counter counts MEM cycles without ack; on reaching MEM_TIMEOUT: err=1, mem_req drops, -> HALT.
//   HALT: done=~err; stays until start (re-run from pc=0) or reset.
//  Branch (EXEC only): taken = (branch_flag ? neg_flag : zero_flag) ^ branch_inv.
//   abs_branch&taken -> pc=abs_target; rel_branch&taken -> pc=pc+sext(instr_off); else pc=pc+1.
//   abs and rel both set: abs wins. Branches never assert reg_we_en.
//  Width/wrap: pc+1 at all-ones wraps to 0; rel add modulo 2**PC_W.
//  Latency: ALU/branch instr = 2 cycles; load/store = 3 + ack wait cycles.
//  cycle_count increments every non-IDLE, non-HALT cycle; saturates, never wraps.
//  mem_ack outside MEM ignored; start outside IDLE/HALT ignored.
//  Reset mid-operation (incl. MEM with req high): immediate return to reset values.
// STRUCTURE
//  Package core_seq_pkg: state_t enum {IDLE,FETCH,EXEC,MEM,HALT}; PC_W/OFF_W defaults.
//  Sub-module branch_unit (combinational): flags+strobes+pc+offset+target -> next_pc, taken.
//  Top: FSM, PC register, MEM wait counter, cycle counter, sticky done/err.
// TESTING
//  start, 3 ADDs then HALT -> pc 0,1,2,3; reg_we_en 3 single-cycle pulses; done=1; cycle_count=7.
//  pc=5, rel_branch, off=6'h3E, zero_flag=1 -> pc=3; same with branch_inv=1 -> pc=6.
//  pc=1023 non-branch -> pc=0; abs_branch, neg_flag=1, flag=1, target=10'h2A -> pc=0x2A.
//  LOD, mem_ack after 4 cycles -> mem_req high 4 cycles, we=0, reg_we_en pulse on ack cycle.
//  STO, no ack -> after 15 MEM cycles err=1, mem_req=0, HALT, done=0; start reruns at pc=0.
//  rst_n low during MEM with mem_req=1 -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared types and default widths for the fetch/execute sequencer.
package core_seq_pkg;

    localparam int PC_W_DEF        = 10;
    localparam int OFF_W_DEF       = 6;
    localparam int MEM_TIMEOUT_DEF = 15;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        HALT
    } state_t;

endpackage

// File: rtl/branch_unit.sv
// Branch resolution: flag test, taken decision and branch target selection.
module branch_unit
    import core_seq_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] instr_off,
    input  logic             abs_branch,
    input  logic             rel_branch,
    input  logic             branch_flag,
    input  logic             branch_inv,
    input  logic             zero_flag,
    input  logic             neg_flag,
    input  logic [PC_W-1:0]  abs_target,
    output logic [PC_W-1:0]  target_pc,
    output logic             taken
);

    logic            cond;
    logic [PC_W-1:0] off_ext;

    assign cond    = (branch_flag ? neg_flag : zero_flag) ^ branch_inv;
    assign off_ext = {{(PC_W-OFF_W){instr_off[OFF_W-1]}}, instr_off};
    assign taken   = (abs_branch | rel_branch) & cond;

    // Absolute wins when the decoder raises both strobes
    always_comb begin
        target_pc = pc + off_ext;
        if (abs_branch) target_pc = abs_target;
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM sequencer: PC, memory handshake, write gating, done/err.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int OFF_W       = OFF_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OFF_W-1:0] instr_off,
    input  logic             abs_branch,
    input  logic             rel_branch,
    input  logic             branch_flag,
    input  logic             branch_inv,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             halt_i,
    input  logic             zero_flag,
    input  logic             neg_flag,
    input  logic [PC_W-1:0]  abs_target,
    input  logic             mem_ack,
    output logic [PC_W-1:0]  pc,
    output logic             ir_load,
    output logic             reg_we_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [PC_W-1:0]   br_pc;
    logic              br_taken;
    logic              running;

    branch_unit #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_branch (
        .pc          (pc_q),
        .instr_off   (instr_off),
        .abs_branch  (abs_branch),
        .rel_branch  (rel_branch),
        .branch_flag (branch_flag),
        .branch_inv  (branch_inv),
        .zero_flag   (zero_flag),
        .neg_flag    (neg_flag),
        .abs_target  (abs_target),
        .target_pc   (br_pc),
        .taken       (br_taken)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        err_d     = err_q;
        ir_load   = 1'b0;
        reg_we_en = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        running   = 1'b0;
        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            FETCH: begin
                running = 1'b1;
                ir_load = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                running = 1'b1;
                if (halt_i) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else if (mem_write || mem_to_reg) begin
                    state_d = MEM;
                    wait_d  = '0;
                end else begin
                    reg_we_en = ~(abs_branch | rel_branch);
                    pc_d      = br_taken ? br_pc : pc_q + PC_W'(1);
                    state_d   = FETCH;
                end
            end
            MEM: begin
                running = 1'b1;
                mem_req = 1'b1;
                mem_we  = mem_write;
                if (mem_ack) begin
                    reg_we_en = mem_to_reg;
                    pc_d      = pc_q + PC_W'(1);
                    state_d   = FETCH;
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // The halting cycle itself is not counted as elapsed run time
        if (running && state_d != HALT && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pc          = pc_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed-vector bench for core_sequencer: ALU run, branches, load, store timeout, reset.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  instr_off;
    logic        abs_branch, rel_branch, branch_flag, branch_inv;
    logic        mem_write, mem_to_reg, halt_i;
    logic        zero_flag, neg_flag;
    logic [9:0]  abs_target;
    logic        mem_ack;
    logic [9:0]  pc;
    logic        ir_load, reg_we_en, mem_req, mem_we, done, err;
    logic [15:0] cycle_count;

    int checks = 0;
    int failures = 0;

    core_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr_off   (instr_off),
        .abs_branch  (abs_branch),
        .rel_branch  (rel_branch),
        .branch_flag (branch_flag),
        .branch_inv  (branch_inv),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .halt_i      (halt_i),
        .zero_flag   (zero_flag),
        .neg_flag    (neg_flag),
        .abs_target  (abs_target),
        .mem_ack     (mem_ack),
        .pc          (pc),
        .ir_load     (ir_load),
        .reg_we_en   (reg_we_en),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .done        (done),
        .err         (err),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic clr_inputs();
        instr_off   = '0;
        abs_branch  = 1'b0;
        rel_branch  = 1'b0;
        branch_flag = 1'b0;
        branch_inv  = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        halt_i      = 1'b0;
        zero_flag   = 1'b0;
        neg_flag    = 1'b0;
        abs_target  = '0;
        mem_ack     = 1'b0;
    endtask

    // From IDLE/HALT: pulse start, return one step into the first FETCH
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // From FETCH: drive one EXEC cycle, capture reg_we_en, land in next state
    task automatic exec_instr(input logic ab, input logic rl, input logic fl,
                              input logic iv, input logic z, input logic n,
                              input logic [5:0] off, input logic [9:0] tgt,
                              output logic we);
        @(posedge clk); #1;
        abs_branch = ab; rel_branch = rl; branch_flag = fl;
        branch_inv = iv; zero_flag = z; neg_flag = n;
        instr_off = off; abs_target = tgt;
        #1;
        we = reg_we_en;
        @(posedge clk); #1;
        clr_inputs();
    endtask

    // From FETCH: EXEC a HALT instruction
    task automatic do_halt();
        @(posedge clk); #1;
        halt_i = 1'b1;
        @(posedge clk); #1;
        halt_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        clr_inputs();
        #2;
        checks++;
        if ({pc, ir_load, reg_we_en, mem_req, mem_we, done, err, cycle_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs pc=%0h ir=%b we=%b req=%b mwe=%b done=%b err=%b cnt=%0d exp all zero",
                     pc, ir_load, reg_we_en, mem_req, mem_we, done, err, cycle_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ir_load !== 1'b0 || pc !== 10'd0) begin
            failures++;
            $display("FAIL idle_no_start ir_load=%b pc=%0h exp 0 0", ir_load, pc);
        end
    endtask

    task automatic test_alu_run();
        logic we;
        do_start();
        checks++;
        if (pc !== 10'd0 || ir_load !== 1'b1) begin
            failures++;
            $display("FAIL start_fetch pc=%0h ir_load=%b exp 0 1", pc, ir_load);
        end
        for (int i = 0; i < 3; i++) begin
            exec_instr(0, 0, 0, 0, 0, 0, 6'h0, 10'h0, we);
            checks++;
            if (we !== 1'b1 || pc !== 10'(i + 1) || ir_load !== 1'b1) begin
                failures++;
                $display("FAIL add_%0d we=%b pc=%0h ir=%b exp 1 %0h 1", i, we, pc, ir_load, i + 1);
            end
        end
        @(posedge clk); #1;
        halt_i = 1'b1;
        #1;
        checks++;
        if (reg_we_en !== 1'b0) begin
            failures++;
            $display("FAIL halt_no_write reg_we_en=%b exp 0", reg_we_en);
        end
        @(posedge clk); #1;
        halt_i = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || pc !== 10'd3 || cycle_count !== 16'd7) begin
            failures++;
            $display("FAIL halt_state done=%b err=%b pc=%0h cnt=%0d exp 1 0 3 7", done, err, pc, cycle_count);
        end
        @(posedge clk); #1;
        checks++;
        if (cycle_count !== 16'd7 || ir_load !== 1'b0) begin
            failures++;
            $display("FAIL halt_frozen cnt=%0d ir=%b exp 7 0", cycle_count, ir_load);
        end
    endtask

    task automatic test_branches();
        logic we;
        do_start();
        exec_instr(1, 0, 0, 0, 1, 0, 6'h0, 10'h5, we);
        checks++;
        if (pc !== 10'h5 || we !== 1'b0) begin
            failures++;
            $display("FAIL abs_to_5 pc=%0h we=%b exp 5 0", pc, we);
        end
        exec_instr(0, 1, 0, 0, 1, 0, 6'h3E, 10'h0, we);
        checks++;
        if (pc !== 10'h3 || we !== 1'b0) begin
            failures++;
            $display("FAIL rel_back pc=%0h we=%b exp 3 0", pc, we);
        end
        exec_instr(1, 0, 0, 0, 1, 0, 6'h0, 10'h5, we);
        exec_instr(0, 1, 0, 1, 1, 0, 6'h3E, 10'h0, we);
        checks++;
        if (pc !== 10'h6 || we !== 1'b0) begin
            failures++;
            $display("FAIL rel_inv_not_taken pc=%0h we=%b exp 6 0", pc, we);
        end
        exec_instr(1, 0, 0, 0, 1, 0, 6'h0, 10'h3FF, we);
        exec_instr(0, 0, 0, 0, 0, 0, 6'h0, 10'h0, we);
        checks++;
        if (pc !== 10'h0 || we !== 1'b1) begin
            failures++;
            $display("FAIL pc_wrap pc=%0h we=%b exp 0 1", pc, we);
        end
        exec_instr(1, 0, 1, 0, 0, 1, 6'h0, 10'h2A, we);
        checks++;
        if (pc !== 10'h2A) begin
            failures++;
            $display("FAIL abs_neg pc=%0h exp 2a", pc);
        end
        exec_instr(1, 1, 0, 0, 1, 0, 6'h01, 10'h100, we);
        checks++;
        if (pc !== 10'h100) begin
            failures++;
            $display("FAIL abs_over_rel pc=%0h exp 100", pc);
        end
        exec_instr(1, 0, 1, 0, 1, 0, 6'h0, 10'h0, we);
        checks++;
        if (pc !== 10'h101 || we !== 1'b0) begin
            failures++;
            $display("FAIL abs_not_taken pc=%0h we=%b exp 101 0", pc, we);
        end
        exec_instr(1, 0, 0, 0, 1, 0, 6'h0, 10'h001, we);
        exec_instr(0, 1, 0, 0, 1, 0, 6'h3C, 10'h0, we);
        checks++;
        if (pc !== 10'h3FD) begin
            failures++;
            $display("FAIL rel_wrap pc=%0h exp 3fd", pc);
        end
        do_halt();
    endtask

    task automatic test_load();
        do_start();
        @(posedge clk); #1;
        mem_to_reg = 1'b1;
        #1;
        checks++;
        if (reg_we_en !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL load_exec we=%b req=%b exp 0 0", reg_we_en, mem_req);
        end
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
            mem_ack = (k == 4);
            #1;
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || reg_we_en !== (k == 4) || pc !== 10'd0) begin
                failures++;
                $display("FAIL load_mem_%0d req=%b mwe=%b we=%b pc=%0h exp 1 0 %0d 0",
                         k, mem_req, mem_we, reg_we_en, pc, (k == 4));
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        mem_to_reg = 1'b0;
        checks++;
        if (pc !== 10'd1 || mem_req !== 1'b0 || ir_load !== 1'b1) begin
            failures++;
            $display("FAIL load_done pc=%0h req=%b ir=%b exp 1 0 1", pc, mem_req, ir_load);
        end
    endtask

    task automatic test_store_timeout();
        @(posedge clk); #1;
        mem_write = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 15; k++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || err !== 1'b0) begin
                failures++;
                $display("FAIL store_wait_%0d req=%b mwe=%b err=%b exp 1 1 0", k, mem_req, mem_we, err);
            end
            @(posedge clk); #1;
        end
        mem_write = 1'b0;
        checks++;
        if (err !== 1'b1 || mem_req !== 1'b0 || done !== 1'b0 || pc !== 10'd1 || cycle_count !== 16'd22) begin
            failures++;
            $display("FAIL timeout err=%b req=%b done=%b pc=%0h cnt=%0d exp 1 0 0 1 22",
                     err, mem_req, done, pc, cycle_count);
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        checks++;
        if (err !== 1'b1 || ir_load !== 1'b0 || pc !== 10'd1) begin
            failures++;
            $display("FAIL halt_hold err=%b ir=%b pc=%0h exp 1 0 1", err, ir_load, pc);
        end
        do_start();
        checks++;
        if (pc !== 10'd0 || err !== 1'b0 || done !== 1'b0 || ir_load !== 1'b1 || cycle_count !== 16'd0) begin
            failures++;
            $display("FAIL rerun pc=%0h err=%b done=%b ir=%b cnt=%0d exp 0 0 0 1 0",
                     pc, err, done, ir_load, cycle_count);
        end
    endtask

    task automatic test_reset_in_mem();
        logic we;
        exec_instr(0, 0, 0, 0, 0, 0, 6'h0, 10'h0, we);
        @(posedge clk); #1;
        mem_to_reg = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b1 || pc !== 10'd1) begin
            failures++;
            $display("FAIL pre_reset_mem req=%b pc=%0h exp 1 1", mem_req, pc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc, ir_load, reg_we_en, mem_req, mem_we, done, err, cycle_count} !== '0) begin
            failures++;
            $display("FAIL async_reset pc=%0h ir=%b we=%b req=%b mwe=%b done=%b err=%b cnt=%0d exp all zero",
                     pc, ir_load, reg_we_en, mem_req, mem_we, done, err, cycle_count);
        end
        clr_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        checks++;
        if (ir_load !== 1'b0 || mem_req !== 1'b0 || pc !== 10'd0 || cycle_count !== 16'd0) begin
            failures++;
            $display("FAIL idle_after_reset ir=%b req=%b pc=%0h cnt=%0d exp 0 0 0 0",
                     ir_load, mem_req, pc, cycle_count);
        end
    endtask

    initial begin
        test_reset();
        test_alu_run();
        test_branches();
        test_load();
        test_store_timeout();
        test_reset_in_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
